// File: rtl/pwm_capture_duty_pkg.sv
// Definitions shared by the motor PWM generator and the PWM capture block.
package pwm_capture_duty_pkg;

  // Full-scale duty value: the generator's 0..999 counter plus the 100 % point.
  localparam int SCALE_PWM = 1000;

  // Width of a duty factor on the 0..SCALE_PWM scale.
  localparam int DUTY_W = 12;

  // Capture sequencer states.
  typedef enum logic {
    IDLE,
    MEASURE
  } cap_state_e;

endpackage

// File: rtl/pwm_div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// N_W iterations. Only the low Q_W quotient bits are exposed. The
// numerator register doubles as the quotient register, since quotient
// bits shift in from the right as numerator bits shift out on the left.
module pwm_div_seq #(
  parameter int N_W = 26,
  parameter int D_W = 16,
  parameter int Q_W = 12
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           abort,
  input  logic           start,
  input  logic [N_W-1:0] numerator,
  input  logic [D_W-1:0] denominator,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quotient
);
  localparam int CW = $clog2(N_W + 1);

  logic [N_W-1:0] quo;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] den;
  logic [CW-1:0]  iter;
  logic [D_W:0]   trial;
  logic           fits;

  // Trial subtraction: shift the next numerator bit into the remainder.
  always_comb begin
    trial = {rem, quo[N_W-1]};
    fits  = (trial >= {1'b0, den});
  end

  // Iteration engine: load on start, one step per clock, pulse done at the end.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      quo  <= '0;
      rem  <= '0;
      den  <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      quo  <= '0;
      rem  <= '0;
      den  <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        quo  <= {quo[N_W-2:0], fits};
        rem  <= fits ? D_W'(trial - {1'b0, den}) : trial[D_W-1:0];
        iter <= iter - CW'(1);
        if (iter == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        quo  <= numerator;
        rem  <= '0;
        den  <= denominator;
        iter <= CW'(N_W);
        busy <= 1'b1;
      end
    end
  end

  assign quotient = quo[Q_W-1:0];

endmodule

// File: rtl/pwm_capture_duty.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// and converts them to a duty factor on the 0..SCALE scale. A pin stuck
// without rising edges for TIMEOUT clocks is reported as 0 % or 100 %.
module pwm_capture_duty
  import pwm_capture_duty_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int SCALE   = SCALE_PWM,
  parameter int TIMEOUT = 4000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              activ,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] factor_PWM,
  output logic [CNT_W-1:0]  perioada,
  output logic [CNT_W-1:0]  durata_high,
  output logic              valid,
  output logic              timeout_flag,
  output logic              overrun
);
  localparam int NUM_W = CNT_W + 10;

  logic              sync_ff1;
  logic              sync_in;
  logic              sync_prev;
  logic              rise;

  cap_state_e        state;
  cap_state_e        state_next;
  logic              take_sample;
  logic              drop_sample;
  logic              hit_timeout;

  logic [CNT_W-1:0]  cnt_per;
  logic [CNT_W-1:0]  cnt_high;
  logic [CNT_W-1:0]  lat_per;
  logic [CNT_W-1:0]  lat_high;
  logic              start_pend;
  logic              discard;

  logic              div_busy;
  logic              div_done;
  logic              div_engaged;
  logic [DUTY_W-1:0] div_quot;
  logic [NUM_W-1:0]  div_num;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_ff1  <= 1'b0;
      sync_in   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff1  <= pwm_in;
      sync_in   <= sync_ff1;
      sync_prev <= sync_in;
    end
  end

  assign rise        = sync_in & ~sync_prev;
  assign div_engaged = div_busy | start_pend;

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle decisions: arm, sample, drop or time out.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next  = state;
    take_sample = 1'b0;
    drop_sample = 1'b0;
    hit_timeout = 1'b0;
    if (!activ) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state_next = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            if (div_engaged) drop_sample = 1'b1;
            else             take_sample = 1'b1;
          end else if (cnt_per == CNT_W'(TIMEOUT)) begin
            hit_timeout = 1'b1;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Period and high-time counters: cleared in IDLE, restarted on each rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_per  <= '0;
      cnt_high <= '0;
    end else if (state_next == IDLE) begin
      cnt_per  <= '0;
      cnt_high <= '0;
    end else if (rise) begin
      cnt_per  <= CNT_W'(1);
      cnt_high <= CNT_W'(sync_in);
    end else begin
      if (cnt_per != '1) cnt_per <= cnt_per + CNT_W'(1);
      if (sync_in && (cnt_high != '1)) cnt_high <= cnt_high + CNT_W'(1);
    end
  end

  // Sample latch, divider launch, result/timeout loading and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_per      <= '0;
      lat_high     <= '0;
      start_pend   <= 1'b0;
      discard      <= 1'b0;
      factor_PWM   <= '0;
      perioada     <= '0;
      durata_high  <= '0;
      valid        <= 1'b0;
      timeout_flag <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      valid      <= 1'b0;
      start_pend <= take_sample;
      if (take_sample) begin
        lat_per  <= cnt_per;
        lat_high <= cnt_high;
      end
      if (drop_sample) overrun <= 1'b1;

      // A divide still running when the input times out must not overwrite
      // the timeout result once it completes.
      if (!activ)           discard <= 1'b0;
      else if (hit_timeout) discard <= div_engaged;
      else if (div_done)    discard <= 1'b0;

      if (hit_timeout) begin
        factor_PWM   <= sync_in ? DUTY_W'(SCALE) : '0;
        perioada     <= '0;
        durata_high  <= cnt_high;
        valid        <= 1'b1;
        timeout_flag <= 1'b1;
      end else if (activ && div_done && !discard) begin
        factor_PWM   <= div_quot;
        perioada     <= lat_per;
        durata_high  <= lat_high;
        valid        <= 1'b1;
        timeout_flag <= 1'b0;
      end
    end
  end

  assign div_num = NUM_W'(lat_high) * NUM_W'(SCALE);

  pwm_div_seq #(
    .N_W (NUM_W),
    .D_W (CNT_W),
    .Q_W (DUTY_W)
  ) u_div (
    .clock       (clock),
    .reset       (reset),
    .abort       (~activ),
    .start       (start_pend),
    .numerator   (div_num),
    .denominator (lat_per),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quot)
  );

endmodule
